// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_pkg                                                       |
// | Purpose  : Shared ALU op codes, datapath width and the multiply-sequencer|
// |            state encoding. Imported by alu and alu_mul_seq.              |
// | Contents : c_XLEN, c_ALU_* op codes, mul_state_t                         |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package alu_pkg;

   localparam int unsigned c_XLEN = 32;

   localparam logic [3:0] c_ALU_AND = 4'b0000;
   localparam logic [3:0] c_ALU_OR  = 4'b0001;
   localparam logic [3:0] c_ALU_ADD = 4'b0010;
   localparam logic [3:0] c_ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } mul_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu                                                           |
// | Purpose  : Purely combinational 32-bit ALU (AND, OR, add, sub).          |
// | Ports    : i_a1, i_a2  operands                                          |
// |            i_ctl       op select (alu_pkg c_ALU_* codes)                 |
// |            o_result    result; unknown op codes yield zero               |
// |            o_zero      high when o_result is zero                        |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module alu
   import alu_pkg::*;
(
   input  logic [c_XLEN-1:0] i_a1,
   input  logic [c_XLEN-1:0] i_a2,
   input  logic [3:0]        i_ctl,
   output logic [c_XLEN-1:0] o_result,
   output logic              o_zero
);

   always_comb begin
      o_result = '0;
      case (i_ctl)
         c_ALU_AND: o_result = i_a1 & i_a2;
         c_ALU_OR:  o_result = i_a1 | i_a2;
         c_ALU_ADD: o_result = i_a1 + i_a2;
         c_ALU_SUB: o_result = i_a1 - i_a2;
         default:   o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule : alu
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_mul_seq                                                   |
// | Purpose  : Shift-and-add 32x32 multiplier (low 32 bits of the product)   |
// |            that borrows an external ALU for its additions.               |
// | Ports    : clk, rst_n       clock, async active-low reset                 |
// |            start, op_a/op_b request + operands, sampled only in IDLE     |
// |            busy, done       busy in RUN/DONE, done is a 1-cycle pulse    |
// |            product          result, held until replaced by the next op   |
// |            alu_a1/a2/ctl    operands and op select driven to the ALU     |
// |            alu_out/zero     ALU result and zero flag                     |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [c_XLEN-1:0] op_a,
   input  logic [c_XLEN-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [c_XLEN-1:0] product,
   output logic [c_XLEN-1:0] alu_a1,
   output logic [c_XLEN-1:0] alu_a2,
   output logic [3:0]        alu_ctl,
   input  logic [c_XLEN-1:0] alu_out,
   input  logic              alu_zero
);

   mul_state_t        r_state;
   mul_state_t        w_state_nxt;
   logic [c_XLEN-1:0] r_acc;
   logic [c_XLEN-1:0] r_m;
   logic [c_XLEN-1:0] r_q;
   logic [4:0]        r_cnt;
   logic [c_XLEN-1:0] r_product;
   logic [c_XLEN-1:0] w_q_shr;

   assign w_q_shr = r_q >> 1;
   assign product = r_product;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and outputs. ALU drive depends only on registered state,
   // so there is no combinational loop through the external ALU.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      alu_ctl     = c_ALU_AND;
      alu_a1      = '0;
      alu_a2      = '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (op_b == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            alu_ctl = c_ALU_ADD;
            alu_a1  = r_acc;
            alu_a2  = r_q[0] ? r_m : '0;
            // Stop once no multiplier bits remain, or after 32 iterations.
            if ((w_q_shr == '0) || (r_cnt == 5'd31)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, shift-and-add iteration, product load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_m       <= '0;
         r_q       <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m   <= op_a;
                  r_q   <= op_b;
                  r_acc <= '0;
                  r_cnt <= '0;
                  // Zero multiplier goes straight to DONE with acc = 0.
                  if (op_b == '0) begin
                     r_product <= '0;
                  end
               end
            end
            S_RUN: begin
               r_acc <= alu_out;
               r_m   <= r_m << 1;
               r_q   <= w_q_shr;
               r_cnt <= r_cnt + 5'd1;
               // The last accumulation is taken straight from the ALU so
               // product is valid in the same cycle done is raised.
               if (w_state_nxt == S_DONE) begin
                  r_product <= alu_out;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The ALU zero flag must agree with its result while we are using it.
   a_alu_zero_consistent : assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_state == S_RUN) |-> (alu_zero == (alu_out == '0))
   );

endmodule : alu_mul_seq
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_mul_seq                                                |
// | Purpose  : Directed self-checking bench for alu_mul_seq with a real alu. |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_alu_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic [31:0] alu_a1;
   logic [31:0] alu_a2;
   logic [3:0]  alu_ctl;
   logic [31:0] alu_out;
   logic        alu_zero;

   int checks = 0;
   int errors = 0;

   int          lat;
   int          busy_n;
   bit          add_seen;
   logic [3:0]  first_ctl;
   logic [31:0] first_a1;
   logic [31:0] first_a2;
   int          done_cnt;

   alu_mul_seq u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .alu_a1   (alu_a1),
      .alu_a2   (alu_a2),
      .alu_ctl  (alu_ctl),
      .alu_out  (alu_out),
      .alu_zero (alu_zero)
   );

   alu u_alu (
      .i_a1     (alu_a1),
      .i_a2     (alu_a2),
      .i_ctl    (alu_ctl),
      .o_result (alu_out),
      .o_zero   (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after the accepting clock edge; samples on each falling
   // edge until done is seen or the cycle budget runs out.
   task automatic wait_done(output int l, output int b, output bit add,
                            output logic [3:0] c1, output logic [31:0] a1,
                            output logic [31:0] a2);
      bit seen;
      l = 0; b = 0; add = 1'b0; seen = 1'b0;
      c1 = 4'hF; a1 = '1; a2 = '1;
      while (!seen && l < 40) begin
         @(negedge clk);
         l++;
         if (busy) b++;
         if (alu_ctl != 4'b0000) add = 1'b1;
         if (l == 1) begin
            c1 = alu_ctl; a1 = alu_a1; a2 = alu_a2;
         end
         seen = done;
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_done",    {31'd0, done},    32'd0);
      chk("rst_product", product,          32'd0);
      chk("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
      chk("rst_alu_a1",  alu_a1,           32'd0);
      chk("rst_alu_a2",  alu_a2,           32'd0);

      // 6 * 7: first start right after reset release
      rst_n = 1'b1;
      launch(32'd6, 32'd7);
      wait_done(lat, busy_n, add_seen, first_ctl, first_a1, first_a2);
      chk("m67_latency",   lat,                 32'd4);
      chk("m67_product",   product,             32'd42);
      chk("m67_busy_cyc",  busy_n,              32'd4);
      chk("m67_ctl_run",   {28'd0, first_ctl},  32'd2);
      chk("m67_a1_run",    first_a1,            32'd0);
      chk("m67_a2_run",    first_a2,            32'd6);
      @(negedge clk);
      chk("m67_done_drop", {31'd0, done},       32'd0);
      chk("m67_busy_drop", {31'd0, busy},       32'd0);
      chk("m67_hold",      product,             32'd42);

      // op_b = 0: immediate done, ALU never leaves AND
      launch(32'h0000_1234, 32'd0);
      wait_done(lat, busy_n, add_seen, first_ctl, first_a1, first_a2);
      chk("zero_latency",  lat,                  32'd1);
      chk("zero_product",  product,              32'd0);
      chk("zero_ctl_and",  {31'd0, add_seen},    32'd0);
      @(negedge clk);

      // All-ones squared wraps to 1
      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, busy_n, add_seen, first_ctl, first_a1, first_a2);
      chk("ones_latency",  lat,     32'd33);
      chk("ones_product",  product, 32'h0000_0001);
      @(negedge clk);

      // MSB-only multiplier, overflow discarded
      launch(32'd3, 32'h8000_0000);
      wait_done(lat, busy_n, add_seen, first_ctl, first_a1, first_a2);
      chk("msb_latency",   lat,      32'd33);
      chk("msb_product",   product,  32'h8000_0000);
      chk("msb_a2_run",    first_a2, 32'd0);
      @(negedge clk);

      // Held start: 5*5 in flight, operands change, start stays high
      op_a = 32'd5; op_b = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 begin op_a = 32'd2; op_b = 32'd2; end
      wait_done(lat, busy_n, add_seen, first_ctl, first_a1, first_a2);
      chk("held1_latency", lat,     32'd4);
      chk("held1_product", product, 32'd25);
      @(negedge clk);
      chk("held_idle",     {31'd0, busy}, 32'd0);
      chk("held_keep",     product,       32'd25);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, busy_n, add_seen, first_ctl, first_a1, first_a2);
      chk("held2_latency", lat,     32'd3);
      chk("held2_product", product, 32'd4);
      @(negedge clk);

      // Mid-RUN reset aborts, no done afterwards
      launch(32'd9, 32'h0000_00FF);
      repeat (3) @(negedge clk);
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy",    {31'd0, busy},    32'd0);
      chk("abort_product", product,          32'd0);
      chk("abort_ctl",     {28'd0, alu_ctl}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 32'd0);
      launch(32'd2, 32'd3);
      wait_done(lat, busy_n, add_seen, first_ctl, first_a1, first_a2);
      chk("post_latency",  lat,     32'd3);
      chk("post_product",  product, 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_mul_seq
`default_nettype wire

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  request a multiply; sampled only in IDLE
- op_a  in  32  multiplicand; captured on accepted start
- op_b  in  32  multiplier; captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; product valid
- product  out  32  low 32 bits of op_a*op_b; held until the next accepted start
- alu_a1  out  32  ALU operand 1
- alu_a2  out  32  ALU operand 2
- alu_ctl  out  4  ALU op select
- alu_out  in  32  ALU result, combinational from alu_a1/alu_a2/alu_ctl
- alu_zero  in  1  ALU zero flag; unused except by assertions

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE.
REQ-004 In IDLE with start=1, the block SHALL capture M=op_a, Q=op_b and acc=0, and clear the iteration counter cnt (5 bits).
REQ-005 If the captured op_b is 0, the next state SHALL be DONE; otherwise it SHALL be RUN.
REQ-006 In RUN, the block SHALL drive alu_ctl=add (4'b0010), alu_a1=acc, and alu_a2=(Q[0] ? M : 0).
REQ-007 Each RUN cycle SHALL perform: acc<=alu_out; M<=M<<1; Q<=Q>>1; cnt<=cnt+1.
REQ-008 RUN SHALL exit to DONE at the end of the cycle in which (Q>>1)==0 or cnt==31; otherwise it SHALL stay in RUN.
REQ-009 On entering DONE, product SHALL be loaded from the final acc.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-011 Latency from the accepted-start edge to done high SHALL be k+1 cycles, where k = (bit index of the MSB set in op_b)+1, giving a range of 2..33.
REQ-012 For op_b=0, done SHALL be asserted 1 cycle after start and product SHALL be 0.
REQ-013 Arithmetic SHALL be modulo 2^32; overflow bits are discarded silently and no flag is raised.
REQ-014 start SHALL be ignored while busy=1 (RUN or DONE); a held start SHALL be accepted on the first IDLE cycle.
REQ-015 Outside RUN, the block SHALL drive alu_ctl=AND (4'b0000), alu_a1=0 and alu_a2=0.
REQ-016 op_a and op_b changes after capture SHALL have no effect on the operation in flight.
REQ-017 The block SHALL contain no combinational path from alu_out to the alu_a1, alu_a2 or alu_ctl outputs.

Reset
REQ-018 While rst_n=0, the block SHALL hold state=IDLE, busy=0, done=0, product=0, acc=0, M=0, Q=0, cnt=0, and ALU outputs at the REQ-015 values.
REQ-019 Reset asserted mid-RUN SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-020 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Structure
REQ-021 ALU op codes (AND 0000, OR 0001, add 0010, sub 0110) and the FSM state encoding SHALL live in the shared package alu_pkg, which is reused by the ALU and by this block.
REQ-022 The ALU SHALL stay external, with the top level wiring alu_a1/alu_a2/alu_ctl/alu_out/alu_zero to one alu instance.
REQ-023 No sub-module is required; the FSM, counter and shift registers SHALL live in alu_mul_seq.

Verification
REQ-024 The bench SHALL use a real alu instance and cover these directed scenarios:
- op_a=6, op_b=7, start pulse -> done exactly 4 cycles after start; product=42; busy high for 4 cycles.
- op_a=0x1234, op_b=0 -> done 1 cycle after start; product=0; alu_ctl stays 0000 throughout.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done 33 cycles after start; product=0x00000001.
- op_a=3, op_b=0x80000000 -> done 33 cycles after start; product=0x80000000.
- op_a=5, op_b=5 accepted, then start held high with op_a=2, op_b=2 -> first product=25, no second capture until IDLE; second product=4.
- Mid-RUN reset with op_b=0xFF, rst_n low at cycle 3 -> busy=0 and product=0 immediately; no done pulse; a following 2*3 yields 6.
